oddr_bank: RTL

ODDR_BANK -- requirements
Module: oddr_bank

---
 rtl/oddr_bank_pkg.sv | 23 ++
 rtl/oddr_bank_train.sv | 94 +++++++++
 rtl/oddr_bank.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/oddr_bank_pkg.sv
// Shared definitions for the oddr_bank DDR output register bank.
// Holds the capture-alignment mode numbers, the training FSM state
// encoding and the logic levels driven during a training burst.
// No ports (package).
package oddr_bank_pkg;

   // Capture alignment modes (value of the DDR_ALIGNMENT parameter)
   localparam int ALIGN_OPPOSITE_EDGE       = 0;
   localparam int ALIGN_SAME_EDGE           = 1;
   localparam int ALIGN_SAME_EDGE_PIPELINED = 2;

   // Training FSM state encoding
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } train_state_e;

   // Training pattern: every bit high in the high phase, low in the low phase
   localparam logic TRAIN_POS_LEVEL = 1'b1;
   localparam logic TRAIN_NEG_LEVEL = 1'b0;

endpackage

// File: rtl/oddr_bank_train.sv
// Training burst sequencer for oddr_bank.
// Ports:
//   clk          - bank clock (posedge only)
//   rst_n        - asynchronous active-low reset
//   ce           - FSM advances only while high
//   train        - burst request level
//   pos_pattern  - next posedge of the bank must drive the high pattern
//   neg_pattern  - next negedge of the bank must drive the low pattern
//   train_done   - registered, high only in DONE
module oddr_bank_train
   import oddr_bank_pkg::*;
#(
   parameter int TRAIN_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ce,
   input  logic train,
   output logic pos_pattern,
   output logic neg_pattern,
   output logic train_done
);

   localparam logic [7:0] CNT_LAST = 8'(TRAIN_CYCLES - 1);

   train_state_e state_r;
   train_state_e state_nxt_s;
   logic [7:0]   cnt_r;
   logic [7:0]   cnt_nxt_s;
   logic         done_r;

   // Next-state and counter logic; exit from RUN at terminal count keeps the
   // counter from ever wrapping.
   always_comb begin
      state_nxt_s = state_r;
      cnt_nxt_s   = cnt_r;
      if (ce) begin
         case (state_r)
            ST_IDLE: begin
               if (train) begin
                  state_nxt_s = ST_RUN;
                  cnt_nxt_s   = 8'd0;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_RUN: begin
               if (!train) begin
                  state_nxt_s = ST_IDLE;
               end else if (cnt_r == CNT_LAST) begin
                  state_nxt_s = ST_DONE;
               end else begin
                  cnt_nxt_s = cnt_r + 8'd1;
               end
            end
            ST_DONE: begin
               if (!train) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_DONE;
               end
            end
            default: begin
               state_nxt_s = ST_IDLE;
               cnt_nxt_s   = 8'd0;
            end
         endcase
      end else begin
         state_nxt_s = state_r;
         cnt_nxt_s   = cnt_r;
      end
   end

   // State, counter and done-flag registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cnt_r   <= 8'd0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         cnt_r   <= cnt_nxt_s;
         done_r  <= (state_nxt_s == ST_DONE);
      end
   end

   // The posedge pattern looks at the state being entered so that the burst
   // starts on the very edge that sees TRAIN and data resumes on the edge
   // that leaves RUN; the negedge follows the state already registered.
   assign pos_pattern = (state_nxt_s == ST_RUN);
   assign neg_pattern = (state_r == ST_RUN);
   assign train_done  = done_r;

endmodule

// File: rtl/oddr_bank.sv
// DDR output register bank with selectable capture alignment and an
// optional training-burst generator (enabled by macro ODDR_BANK_TRAIN_EN).
// Ports:
//   C          - clock, both edges used
//   R_N        - asynchronous active-low reset (Q = INIT)
//   CE         - clock enable for all capture registers
//   R / S      - synchronous reset-to-0 / set-to-1 of Q, per edge
//   D0 / D1    - rising-edge / falling-edge data
//   TRAIN      - training burst request level
//   TRAIN_DONE - burst complete flag
//   Q          - DDR output bus
module oddr_bank
   import oddr_bank_pkg::*;
#(
   parameter int               WIDTH         = 8,
   parameter int               DDR_ALIGNMENT = 0,
   parameter logic [WIDTH-1:0] INIT          = {WIDTH{1'b0}},
   parameter int               TRAIN_CYCLES  = 16
) (
   input  logic             C,
   input  logic             R_N,
   input  logic             CE,
   input  logic             R,
   input  logic             S,
   input  logic [WIDTH-1:0] D0,
   input  logic [WIDTH-1:0] D1,
   input  logic             TRAIN,
   output logic             TRAIN_DONE,
   output logic [WIDTH-1:0] Q
);

   logic [WIDTH-1:0] q_pos_r;
   logic [WIDTH-1:0] q_neg_r;
   logic [WIDTH-1:0] d0_p1_r;
   logic [WIDTH-1:0] d1_p1_r;
   logic [WIDTH-1:0] d1_cap_r;
   logic             ce_cap_r;
   logic [WIDTH-1:0] pos_d_s;
   logic [WIDTH-1:0] neg_d_s;
   logic             neg_hold_s;
   logic             pos_pat_s;
   logic             neg_pat_s;

`ifdef ODDR_BANK_TRAIN_EN
   oddr_bank_train #(
      .TRAIN_CYCLES (TRAIN_CYCLES)
   ) u_train (
      .clk         (C),
      .rst_n       (R_N),
      .ce          (CE),
      .train       (TRAIN),
      .pos_pattern (pos_pat_s),
      .neg_pattern (neg_pat_s),
      .train_done  (TRAIN_DONE)
   );
`else
   logic unused_train_s;
   assign unused_train_s = TRAIN;
   assign pos_pat_s      = 1'b0;
   assign neg_pat_s      = 1'b0;
   assign TRAIN_DONE     = 1'b0;
`endif

   // Data source per edge; in the same-edge modes a posedge with CE low
   // also freezes the following negedge.
   always_comb begin
      pos_d_s    = D0;
      neg_d_s    = D1;
      neg_hold_s = !CE;
      if (DDR_ALIGNMENT == ALIGN_SAME_EDGE_PIPELINED) begin
         pos_d_s = d0_p1_r;
      end else begin
         pos_d_s = D0;
      end
      if (DDR_ALIGNMENT == ALIGN_OPPOSITE_EDGE) begin
         neg_d_s    = D1;
         neg_hold_s = !CE;
      end else begin
         neg_d_s    = d1_cap_r;
         neg_hold_s = !CE || !ce_cap_r;
      end
   end

   // Posedge capture and pipeline stages for the same-edge modes
   always_ff @(posedge C or negedge R_N) begin
      if (!R_N) begin
         d0_p1_r  <= {WIDTH{1'b0}};
         d1_p1_r  <= {WIDTH{1'b0}};
         d1_cap_r <= {WIDTH{1'b0}};
         ce_cap_r <= 1'b0;
      end else begin
         ce_cap_r <= CE;
         if (CE) begin
            d0_p1_r <= D0;
            d1_p1_r <= D1;
            if (DDR_ALIGNMENT == ALIGN_SAME_EDGE_PIPELINED) begin
               d1_cap_r <= d1_p1_r;
            end else begin
               d1_cap_r <= D1;
            end
         end else begin
            d0_p1_r  <= d0_p1_r;
            d1_p1_r  <= d1_p1_r;
            d1_cap_r <= d1_cap_r;
         end
      end
   end

   // High-phase output register; holding means keeping the value Q showed
   // during the preceding low phase.
   always_ff @(posedge C or negedge R_N) begin
      if (!R_N) begin
         q_pos_r <= INIT;
      end else if (R) begin
         q_pos_r <= {WIDTH{1'b0}};
      end else if (S) begin
         q_pos_r <= {WIDTH{1'b1}};
      end else if (!CE) begin
         q_pos_r <= q_neg_r;
      end else if (pos_pat_s) begin
         q_pos_r <= {WIDTH{TRAIN_POS_LEVEL}};
      end else begin
         q_pos_r <= pos_d_s;
      end
   end

   // Low-phase output register
   always_ff @(negedge C or negedge R_N) begin
      if (!R_N) begin
         q_neg_r <= INIT;
      end else if (R) begin
         q_neg_r <= {WIDTH{1'b0}};
      end else if (S) begin
         q_neg_r <= {WIDTH{1'b1}};
      end else if (neg_hold_s) begin
         q_neg_r <= q_pos_r;
      end else if (neg_pat_s) begin
         q_neg_r <= {WIDTH{TRAIN_NEG_LEVEL}};
      end else begin
         q_neg_r <= neg_d_s;
      end
   end

   // DDR mux: the clock level selects which phase register drives the pin
   assign Q = C ? q_pos_r : q_neg_r;

endmodule
